conv1x1_frame_sequencer: RTL and testbench

- Frame-level controller for the 4-output/12-input 1x1 convolution layer.
- Pulls a frame of IMG_Width*IMG_Height pixel vectors from the upstream line/feature buffer and issues them to the layer's valid_in.
- Throttles issue with a credit counter, because the layer has no backpressure and the downstream result FIFO has a fixed depth.
- Tags each result with its row/column and signals frame completion.

---
 rtl/conv_seq_pkg.sv | 19 +
 rtl/conv1x1_frame_sequencer_credit_counter.sv | 33 +++
 rtl/conv1x1_frame_sequencer.sv | 169 ++++++++++++++++
 tb/tb_conv1x1_frame_sequencer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/conv_seq_pkg.sv
// Shared types and helpers for the 1x1 conv frame sequencer.
// State encoding, default counter width, frame size helper.
package conv_seq_pkg;

  localparam int CNT_W_DEF = 16;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FLUSH = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  function automatic int frame_pixels(input int w, input int h);
    return w * h;
  endfunction

endpackage

// File: rtl/conv1x1_frame_sequencer_credit_counter.sv
// Up/down saturating credit counter for the result FIFO slots.
// Ports: clk, rst (sync active-low), i_take, i_give, o_has_credit, o_overflow_err.
module credit_counter #(
  parameter int CREDITS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_take,
  input  logic i_give,
  output logic o_has_credit,
  output logic o_overflow_err
);

  localparam int W = $clog2(CREDITS + 1);
  localparam logic [W-1:0] MAX = W'(CREDITS);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= MAX;
    end else if (i_take && !i_give) begin
      if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
    end else if (i_give && !i_take) begin
      if (r_cnt != MAX) r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_has_credit   = (r_cnt != '0);
  // A return with every slot already free has no matching issue.
  assign o_overflow_err = i_give & ~i_take & (r_cnt == MAX);

endmodule

// File: rtl/conv1x1_frame_sequencer.sv
// Frame sequencer for the 1x1 conv layer: credit-throttled issue,
// row/col result tagging, frame completion. Optional stats: CONV1X1_SEQ_STATS_EN.
// Ports: clk, rst (sync active-low), start, busy, frame_done, pix_valid,
// pix_ready, conv_rst, conv_valid_in, conv_valid_out, res_push, res_row,
// res_col, credit_return, err [, stall_cycles, frame_cycles].
module conv1x1_frame_sequencer
  import conv_seq_pkg::*;
#(
  parameter int IMG_Width  = 3,
  parameter int IMG_Height = 3,
  parameter int CREDITS    = 4,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             frame_done,
  input  logic             pix_valid,
  output logic             pix_ready,
  output logic             conv_rst,
  output logic             conv_valid_in,
  input  logic             conv_valid_out,
  output logic             res_push,
  output logic [CNT_W-1:0] res_row,
  output logic [CNT_W-1:0] res_col,
  input  logic             credit_return,
`ifdef CONV1X1_SEQ_STATS_EN
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] frame_cycles,
`endif
  output logic             err
);

  localparam logic [CNT_W-1:0] N =
    CNT_W'(frame_pixels(IMG_Width, IMG_Height));
  localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(IMG_Width - 1);

  state_t r_state, w_next;

  logic [CNT_W-1:0] r_issued;
  logic [CNT_W-1:0] r_received;
  logic [CNT_W-1:0] r_row;
  logic [CNT_W-1:0] r_col;
  logic             r_err;

  logic w_busy;
  logic w_ready;
  logic w_issue;
  logic w_push;
  logic w_start;
  logic w_rcv_full;
  logic w_rcv_last;
  logic w_has_credit;
  logic w_ovf;
  logic w_err_set;

  credit_counter #(
    .CREDITS(CREDITS)
  ) u_credit (
    .clk           (clk),
    .rst           (rst),
    .i_take        (w_issue),
    .i_give        (credit_return),
    .o_has_credit  (w_has_credit),
    .o_overflow_err(w_ovf)
  );

  assign w_busy  = (r_state == S_FLUSH) ||
                   (r_state == S_RUN)   ||
                   (r_state == S_DRAIN);
  assign w_ready = (r_state == S_RUN) &&
                   (r_issued < N) && w_has_credit;
  assign w_issue = pix_valid & w_ready;
  assign w_push  = conv_valid_out & w_busy;
  assign w_start = start && (r_state == S_IDLE);

  assign w_rcv_full = (r_received == N);
  assign w_rcv_last = w_push && (r_received == N - 1'b1);

  // Results with no matching issue: layer should be quiet outside a frame.
  assign w_err_set = w_ovf |
                     (conv_valid_out & (r_state == S_IDLE)) |
                     (conv_valid_out & (r_state == S_FLUSH)) |
                     (conv_valid_out & w_rcv_full);

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_next = S_FLUSH;
      S_FLUSH: w_next = S_RUN;
      S_RUN: begin
        if (w_issue && (r_issued == N - 1'b1))
          w_next = w_rcv_last ? S_DONE : S_DRAIN;
      end
      S_DRAIN: if (w_rcv_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_issued   <= '0;
      r_received <= '0;
      r_row      <= '0;
      r_col      <= '0;
      r_err      <= 1'b0;
    end else if (w_start) begin
      r_issued   <= '0;
      r_received <= '0;
      r_row      <= '0;
      r_col      <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_issue) r_issued <= r_issued + 1'b1;
      if (w_push && !w_rcv_full) begin
        r_received <= r_received + 1'b1;
        if (r_col == COL_LAST) begin
          r_col <= '0;
          r_row <= r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
      if (w_err_set) r_err <= 1'b1;
    end
  end

`ifdef CONV1X1_SEQ_STATS_EN
  logic [CNT_W-1:0] r_stall;
  logic [CNT_W-1:0] r_fcyc;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_stall <= '0;
      r_fcyc  <= '0;
    end else if (w_start) begin
      r_stall <= '0;
      r_fcyc  <= '0;
    end else begin
      if ((r_state == S_RUN) && pix_valid &&
          !w_has_credit && (r_stall != '1))
        r_stall <= r_stall + 1'b1;
      if ((w_busy || (r_state == S_DONE)) && (r_fcyc != '1))
        r_fcyc <= r_fcyc + 1'b1;
    end
  end

  assign stall_cycles = r_stall;
  assign frame_cycles = r_fcyc;
`endif

  assign busy          = w_busy;
  assign frame_done    = (r_state == S_DONE);
  assign pix_ready     = w_ready;
  assign conv_rst      = ~rst | (r_state == S_FLUSH);
  assign conv_valid_in = w_issue;
  assign res_push      = w_push;
  assign res_row       = r_row;
  assign res_col       = r_col;
  assign err           = r_err;

endmodule

// File: tb/tb_conv1x1_frame_sequencer.sv
// Self-checking bench for conv1x1_frame_sequencer (3x3 frame, 4 credits).
// Random pixel/credit stimulus against a counting reference model.
module tb_conv1x1_frame_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, pix_valid, conv_valid_out, credit_return;
  logic        busy, frame_done, pix_ready, conv_rst, conv_valid_in;
  logic        res_push, err;
  logic [15:0] res_row, res_col;
`ifdef CONV1X1_SEQ_STATS_EN
  logic [15:0] stall_cycles, frame_cycles;
`endif

  conv1x1_frame_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .busy          (busy),
    .frame_done    (frame_done),
    .pix_valid     (pix_valid),
    .pix_ready     (pix_ready),
    .conv_rst      (conv_rst),
    .conv_valid_in (conv_valid_in),
    .conv_valid_out(conv_valid_out),
    .res_push      (res_push),
    .res_row       (res_row),
    .res_col       (res_col),
    .credit_return (credit_return),
`ifdef CONV1X1_SEQ_STATS_EN
    .stall_cycles  (stall_cycles),
    .frame_cycles  (frame_cycles),
`endif
    .err           (err)
  );

  localparam int NPIX = 9;
  localparam int W    = 3;
  localparam int CRED = 4;

  int n_cmp = 0;
  int n_bad = 0;
  int m_cred = CRED;

  task automatic drive(input logic s, input logic pv,
                       input logic cvo, input logic cr);
    start = s; pix_valid = pv; conv_valid_out = cvo; credit_return = cr;
  endtask

  task automatic do_start();
    @(negedge clk); drive(1, 0, 0, 0); #1;
    @(negedge clk); drive(0, 0, 0, 0); #1;
    n_cmp++; if (conv_rst !== 1'b1) begin n_bad++; $display("FAIL flush_conv_rst got %b want 1", conv_rst); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL flush_busy got %b want 1", busy); end
    n_cmp++; if (pix_ready !== 1'b0) begin n_bad++; $display("FAIL flush_ready got %b want 0", pix_ready); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL flush_err got %b want 0", err); end
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b0; drive(0, 0, 0, 0); #1;
    @(negedge clk); rst = 1'b1; #1;
    m_cred = CRED;
  endtask

  // Full frame: phase 1=run, 2=drain, 3=done. mode 0 returns a credit
  // one cycle after each push, mode 1 pops the FIFO at random.
  task automatic run_frame(input int pv_pct, input int mode,
                           input int start_at);
    int iss, rcv, pend, phase, issues, pushes, dones;
    bit p1, p2, prevpush, fin, pv, cvo, ret, ex_rdy, ex_push, ex_iss;
    iss = 0; rcv = 0; pend = 0; phase = 1;
    issues = 0; pushes = 0; dones = 0;
    p1 = 0; p2 = 0; prevpush = 0; fin = 0;
    do_start();
    for (int c = 0; c < 400 && !fin; c++) begin
      @(negedge clk);
      pv  = ($urandom_range(99) < pv_pct);
      cvo = p2;
      ret = (mode == 0) ? prevpush : (pend > 0 && $urandom_range(1) == 1);
      drive(c == start_at, pv, cvo, ret);
      #1;
      ex_rdy  = (phase == 1) && (iss < NPIX) && (m_cred > 0);
      ex_iss  = pv && ex_rdy;
      ex_push = cvo && (phase != 3);
      n_cmp++; if (pix_ready !== ex_rdy) begin n_bad++; $display("FAIL ready c=%0d got %b want %b", c, pix_ready, ex_rdy); end
      n_cmp++; if (conv_valid_in !== ex_iss) begin n_bad++; $display("FAIL valid_in c=%0d got %b want %b", c, conv_valid_in, ex_iss); end
      n_cmp++; if (res_push !== ex_push) begin n_bad++; $display("FAIL push c=%0d got %b want %b", c, res_push, ex_push); end
      n_cmp++; if (frame_done !== (phase == 3)) begin n_bad++; $display("FAIL done c=%0d got %b want %b", c, frame_done, phase == 3); end
      n_cmp++; if (busy !== (phase != 3)) begin n_bad++; $display("FAIL busy c=%0d got %b want %b", c, busy, phase != 3); end
      n_cmp++; if (conv_rst !== 1'b0) begin n_bad++; $display("FAIL run_conv_rst c=%0d got %b want 0", c, conv_rst); end
      n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL run_err c=%0d got %b want 0", c, err); end
      if (ex_push) begin
        n_cmp++; if (res_row !== 16'(rcv / W) || res_col !== 16'(rcv % W)) begin n_bad++; $display("FAIL tag #%0d got (%0d,%0d) want (%0d,%0d)", rcv, res_row, res_col, rcv / W, rcv % W); end
      end
      if (frame_done === 1'b1) dones++;
      if (ex_iss) begin iss++; m_cred--; issues++; end
      if (ret) begin m_cred++; pend--; end
      if (ex_push) begin rcv++; pend++; pushes++; end
      prevpush = ex_push; p2 = p1; p1 = ex_iss;
      if (phase == 3) fin = 1;
      else begin
        if (phase == 1 && iss == NPIX) phase = 2;
        if (phase == 2 && rcv == NPIX) phase = 3;
      end
    end
    n_cmp++; if (!fin) begin n_bad++; $display("FAIL frame_timeout got phase %0d want done", phase); end
    n_cmp++; if (issues != NPIX || pushes != NPIX || dones != 1) begin n_bad++; $display("FAIL frame_counts got %0d/%0d/%0d want 9/9/1", issues, pushes, dones); end
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      drive(0, 0, 0, pend > 0);
      #1;
      n_cmp++; if (busy !== 1'b0 || frame_done !== 1'b0 || err !== 1'b0) begin n_bad++; $display("FAIL idle k=%0d got busy=%b done=%b err=%b want 0", k, busy, frame_done, err); end
      if (pend > 0) begin pend--; m_cred++; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; drive(0, 0, 0, 0);
    @(negedge clk); #1;
    n_cmp++; if (conv_rst !== 1'b1) begin n_bad++; $display("FAIL rst_conv_rst got %b want 1", conv_rst); end
    @(negedge clk); #1;
    n_cmp++; if (busy !== 1'b0 || frame_done !== 1'b0 || err !== 1'b0 || pix_ready !== 1'b0) begin n_bad++; $display("FAIL rst_outputs got %b%b%b%b want 0000", busy, frame_done, err, pix_ready); end
    rst = 1'b1;
    @(negedge clk); #1;
    n_cmp++; if (conv_rst !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL idle_after_rst got conv_rst=%b busy=%b want 0", conv_rst, busy); end
    m_cred = CRED;
  endtask

  task automatic test_frame_basic();
    run_frame(100, 0, -1);
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 4; f++) run_frame(40 + 15 * f, 1, -1);
  endtask

  task automatic test_start_ignored();
    run_frame(70, 0, 4);
    run_frame(100, 1, 2);
  endtask

  task automatic test_credit_exhaust_reset();
    int cnt;
    do_start();
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); drive(0, 1, 0, 0); #1;
      if (conv_valid_in === 1'b1) cnt++;
    end
    n_cmp++; if (cnt != CRED) begin n_bad++; $display("FAIL exhaust_issues got %0d want %0d", cnt, CRED); end
    n_cmp++; if (pix_ready !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL exhaust_stall got ready=%b busy=%b want 0/1", pix_ready, busy); end
    @(negedge clk); drive(0, 1, 0, 1); #1;
    n_cmp++; if (conv_valid_in !== 1'b0) begin n_bad++; $display("FAIL return_cycle got %b want 0", conv_valid_in); end
    @(negedge clk); rst = 1'b0; drive(0, 1, 0, 0); #1;
    n_cmp++; if (conv_valid_in !== 1'b1 || conv_rst !== 1'b1) begin n_bad++; $display("FAIL fifth_issue got vin=%b conv_rst=%b want 1/1", conv_valid_in, conv_rst); end
    @(negedge clk); rst = 1'b1; #1;
    n_cmp++; if (busy !== 1'b0 || pix_ready !== 1'b0 || conv_valid_in !== 1'b0) begin n_bad++; $display("FAIL post_rst got busy=%b ready=%b want 0", busy, pix_ready); end
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); drive(0, 1, 1'($urandom_range(1)), 0); #1;
      if (frame_done === 1'b1) cnt++;
    end
    n_cmp++; if (cnt != 0) begin n_bad++; $display("FAIL no_done_after_rst got %0d want 0", cnt); end
    do_reset();
  endtask

  task automatic test_simultaneous();
    int cnt;
    do_start();
    @(negedge clk); drive(0, 1, 0, 0); #1;
    cnt = (conv_valid_in === 1'b1) ? 1 : 0;
    @(negedge clk); drive(0, 1, 0, 1); #1;
    n_cmp++; if (conv_valid_in !== 1'b1) begin n_bad++; $display("FAIL simul_issue got %b want 1", conv_valid_in); end
    if (conv_valid_in === 1'b1) cnt++;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); drive(0, 1, 0, 0); #1;
      if (conv_valid_in === 1'b1) cnt++;
    end
    n_cmp++; if (cnt != CRED + 1) begin n_bad++; $display("FAIL simul_count got %0d want %0d", cnt, CRED + 1); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL simul_err got %b want 0", err); end
    do_reset();
  endtask

  task automatic test_errors();
    @(negedge clk); drive(0, 0, 1, 0); #1;
    n_cmp++; if (res_push !== 1'b0) begin n_bad++; $display("FAIL idle_push got %b want 0", res_push); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); drive(0, 0, 0, 0); #1;
      n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL idle_vout_err k=%0d got %b want 1", k, err); end
    end
    do_start();
    do_reset();
    @(negedge clk); drive(0, 0, 0, 1); #1;
    @(negedge clk); drive(0, 0, 0, 0); #1;
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL overflow_err got %b want 1", err); end
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0);
    test_reset();
    test_frame_basic();
    test_back_to_back();
    test_start_ignored();
    test_credit_exhaust_reset();
    test_simultaneous();
    test_errors();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
